counter_cell_scheduler: RTL and testbench
=========================================

# counter_cell_scheduler

Sequences involuntary counter-cell service for the AGC timing chain. It latches up and down increment requests from the counter sources and arbitrates them by fixed priority. At each end-of-MCT boundary (T12) it grants one counter memory cycle, driving the PINC/MINC selection and cell address for that MCT. It sits beside the timer and consumes T12 and GOJAM from it.

## Interface
Parameters:
- NREQ, 8, number of counter cells (request index 0 = highest priority)
- AW, 3, address width; must satisfy 2**AW >= NREQ
- BURST, 4, maximum consecutive counter MCTs before one forced non-counter MCT (1..15)

Ports:
- CLOCK  in  1  system clock; all state updates on its rising edge
- SIM_RST  in  1  reset, synchronous, active-high
- T12  in  1  one-CLOCK pulse marking the end of each MCT
- GOJAM  in  1  restart; synchronous clear of all pending and active state while high
- CTR_INH  in  1  when high at a T12 sample, no new grant is issued for the next MCT
- REQ_PLUS  in  NREQ  level up-count request lines, one per cell
- REQ_MINUS  in  NREQ  level down-count request lines, one per cell
- CTR_ACTIVE  out  1  high for the whole granted counter MCT
- PINC  out  1  granted cycle is an increment
- MINC  out  1  granted cycle is a decrement
- CTR_ADDR  out  AW  index of the granted cell, held for the MCT
- ACK  out  NREQ  one-cycle pulse on the granted cell's bit
- CTROR  out  1  any pending request (combinational OR of the pending registers)
- HOLDOFF  out  1  high during a forced non-counter MCT

## Operation
- Edge capture: the prev_plus and prev_minus registers sample REQ_* every cycle. pend_plus[i] is set on a 0→1 transition of REQ_PLUS[i] (REQ high, prev low); pend_minus works the same way from REQ_MINUS.
- State machine: IDLE, SERVE, HOLD.
  - IDLE at T12: if the pending set is non-empty and CTR_INH = 0, select the lowest index i with pend_plus[i] or pend_minus[i] set. Go to SERVE.
  - SERVE at T12: if burst_cnt == BURST, go to HOLD. Otherwise run the IDLE selection: grant again (burst_cnt+1) or return to IDLE (burst_cnt cleared).
  - HOLD at T12: clear burst_cnt and run the IDLE selection from a count of 0.
- Grant actions:
  - load CTR_ADDR = i;
  - set PINC if pend_plus[i] else MINC (plus wins when both are set and cancellation is compiled out);
  - clear the serviced pending bit;
  - pulse ACK[i];
  - set burst_cnt = 1 on entry from IDLE or HOLD.
- Set and clear in the same cycle: a new edge on the bit being granted sets it again, so a set wins over a grant clear.
- CTR_INH blocks new grants only. It does not abort a SERVE in progress, and it does not clear pending bits.
- GOJAM:
  - clears pending, burst_cnt and outputs;
  - forces IDLE;
  - edges seen while GOJAM is high are discarded (prev registers still track).
- PINC and MINC are mutually exclusive and are 0 whenever CTR_ACTIVE = 0.

## Timing
- Reset values: CTR_ACTIVE = PINC = MINC = HOLDOFF = 0, CTR_ADDR = 0, ACK = 0, CTROR = 0, state IDLE, burst_cnt = 0.
- During reset, prev_* load the current REQ_*, so a line already high at reset release produces no edge.
- Edge sampled at edge k: the pending bit is visible from cycle k+1.
- A T12 sampled at edge k uses the pre-update pending state, so a request edge coinciding with T12 waits one MCT.
- Grant decision at the T12 sampling edge k: CTR_ACTIVE, PINC/MINC and CTR_ADDR are registered and valid from cycle k+1 up to and including the next T12 cycle. ACK is high only in cycle k+1.
- Back-to-back grants keep CTR_ACTIVE continuously high; only CTR_ADDR and PINC/MINC change at the boundary.
- HOLDOFF is high for exactly one MCT, with the same edge alignment as CTR_ACTIVE.
- Precedence in one cycle: SIM_RST > GOJAM > T12 actions.

## Configuration
- CTR_CANCEL_EN defined:
  - when pend_plus[i] and pend_minus[i] are both set after the edge update, both are cleared with no grant and no ACK;
  - an opposite-sign edge arriving while the other bit is pending annihilates it in the same cycle.
- CTR_CANCEL_EN undefined: both bits are kept. The plus is served first; the minus is served at a later T12 according to priority.

## Test plan
- Single request: reset, raise REQ_PLUS[3], then T12 → the next cycle shows CTR_ACTIVE = 1, PINC = 1, CTR_ADDR = 3 and a single-cycle ACK[3]; CTR_ACTIVE drops after the following T12.
- Priority: pend cells 5 and 1 together → grants CTR_ADDR = 1, then 5 on consecutive T12s, with CTR_ACTIVE held continuously high.
- Burst limit (BURST = 4): six cells pending → four counter MCTs, one HOLDOFF MCT, then two more counter MCTs.
- Cancellation: REQ_PLUS[2] and REQ_MINUS[2] edges in the same cycle.
  - With CTR_CANCEL_EN: CTROR stays 0 and no grant occurs.
  - Without it: a PINC grant, then a MINC grant, both at address 2.
- GOJAM mid-SERVE with 3 pending → the next cycle shows CTR_ACTIVE = 0 and CTROR = 0; a subsequent T12 produces no grant.
- CTR_INH high at T12 with cell 0 pending → no grant and CTROR stays 1; after CTR_INH falls, the next T12 grants cell 0.

Source files
------------

// File: rtl/counter_cell_scheduler.sv
// counter_cell_scheduler
// Captures rising edges on the per-cell up/down counter request lines and, at
// each end-of-MCT (T12) boundary, grants one counter memory cycle to the
// lowest-indexed pending cell. After BURST consecutive counter MCTs one
// non-counter MCT is forced (HOLDOFF).
// Optional build macro: CTR_CANCEL_EN -- an up and a down request pending on
// the same cell annihilate each other without a grant.
module counter_cell_scheduler #(
  parameter int NREQ  = 8,
  parameter int AW    = 3,
  parameter int BURST = 4
) (
  input  logic            CLOCK,
  input  logic            SIM_RST,
  input  logic            T12,
  input  logic            GOJAM,
  input  logic            CTR_INH,
  input  logic [NREQ-1:0] REQ_PLUS,
  input  logic [NREQ-1:0] REQ_MINUS,
  output logic            CTR_ACTIVE,
  output logic            PINC,
  output logic            MINC,
  output logic [AW-1:0]   CTR_ADDR,
  output logic [NREQ-1:0] ACK,
  output logic            CTROR,
  output logic            HOLDOFF
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] BURST_C = 4'(BURST);

  state_t          state_q, state_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [NREQ-1:0] prev_plus_q, prev_minus_q;
  logic [NREQ-1:0] pend_plus_q, pend_plus_d;
  logic [NREQ-1:0] pend_minus_q, pend_minus_d;
  logic            ctr_active_q, ctr_active_d;
  logic            pinc_q, pinc_d;
  logic            minc_q, minc_d;
  logic            holdoff_q, holdoff_d;
  logic [AW-1:0]   ctr_addr_q, ctr_addr_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic [NREQ-1:0] edge_plus_s, edge_minus_s, pend_any_s;
  logic [NREQ-1:0] clr_plus_s, clr_minus_s;
  logic [AW-1:0]   sel_idx_s;
  logic            sel_valid_s, sel_plus_s;
  logic            do_hold_s, do_select_s, grant_s;
`ifdef CTR_CANCEL_EN
  logic [NREQ-1:0] cancel_s;
`endif

  // Rising-edge detection and fixed-priority pick of the lowest pending cell
  always_comb begin
    edge_plus_s  = REQ_PLUS  & ~prev_plus_q;
    edge_minus_s = REQ_MINUS & ~prev_minus_q;
    pend_any_s   = pend_plus_q | pend_minus_q;
    sel_idx_s    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sel_idx_s = pend_any_s[i] ? AW'(i) : sel_idx_s;
    end
    sel_valid_s = (|pend_any_s) & ~CTR_INH;
    // Plus wins when both directions are pending on the chosen cell
    sel_plus_s  = pend_plus_q[sel_idx_s];
  end

  // MCT boundary decision: forced hold, new grant, or fall back to idle
  always_comb begin
    do_hold_s    = T12 && (state_q == ST_SERVE) && (burst_cnt_q == BURST_C);
    do_select_s  = T12 && !do_hold_s;
    grant_s      = do_select_s && sel_valid_s;
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    ctr_active_d = ctr_active_q;
    pinc_d       = pinc_q;
    minc_d       = minc_q;
    holdoff_d    = holdoff_q;
    ctr_addr_d   = ctr_addr_q;
    ack_d        = '0;
    clr_plus_s   = '0;
    clr_minus_s  = '0;
    if (GOJAM) begin
      state_d      = ST_IDLE;
      burst_cnt_d  = 4'd0;
      ctr_active_d = 1'b0;
      pinc_d       = 1'b0;
      minc_d       = 1'b0;
      holdoff_d    = 1'b0;
      ctr_addr_d   = '0;
    end else if (do_hold_s) begin
      state_d      = ST_HOLD;
      ctr_active_d = 1'b0;
      pinc_d       = 1'b0;
      minc_d       = 1'b0;
      holdoff_d    = 1'b1;
    end else if (grant_s) begin
      state_d      = ST_SERVE;
      // A grant out of IDLE or HOLD starts a fresh run of counter MCTs
      burst_cnt_d  = (state_q == ST_SERVE) ? (burst_cnt_q + 4'd1) : 4'd1;
      ctr_active_d = 1'b1;
      pinc_d       = sel_plus_s;
      minc_d       = ~sel_plus_s;
      holdoff_d    = 1'b0;
      ctr_addr_d   = sel_idx_s;
      for (int i = 0; i < NREQ; i++) begin
        ack_d[i] = (AW'(i) == sel_idx_s);
      end
      clr_plus_s[sel_idx_s]  = sel_plus_s;
      clr_minus_s[sel_idx_s] = ~sel_plus_s;
    end else if (do_select_s) begin
      state_d      = ST_IDLE;
      burst_cnt_d  = 4'd0;
      ctr_active_d = 1'b0;
      pinc_d       = 1'b0;
      minc_d       = 1'b0;
      holdoff_d    = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // Pending update: grant clear first, then new edges so a set wins the tie
  always_comb begin
    pend_plus_d  = (pend_plus_q  & ~clr_plus_s)  | edge_plus_s;
    pend_minus_d = (pend_minus_q & ~clr_minus_s) | edge_minus_s;
`ifdef CTR_CANCEL_EN
    cancel_s     = pend_plus_d & pend_minus_d;
    pend_plus_d  = pend_plus_d  & ~cancel_s;
    pend_minus_d = pend_minus_d & ~cancel_s;
`endif
    if (GOJAM) begin
      // Edges seen during a restart are dropped along with everything pending
      pend_plus_d  = '0;
      pend_minus_d = '0;
    end else begin
      pend_plus_d  = pend_plus_d;
      pend_minus_d = pend_minus_d;
    end
  end

  // All state, pending and output registers
  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      state_q      <= ST_IDLE;
      burst_cnt_q  <= 4'd0;
      prev_plus_q  <= REQ_PLUS;
      prev_minus_q <= REQ_MINUS;
      pend_plus_q  <= '0;
      pend_minus_q <= '0;
      ctr_active_q <= 1'b0;
      pinc_q       <= 1'b0;
      minc_q       <= 1'b0;
      holdoff_q    <= 1'b0;
      ctr_addr_q   <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      prev_plus_q  <= REQ_PLUS;
      prev_minus_q <= REQ_MINUS;
      pend_plus_q  <= pend_plus_d;
      pend_minus_q <= pend_minus_d;
      ctr_active_q <= ctr_active_d;
      pinc_q       <= pinc_d;
      minc_q       <= minc_d;
      holdoff_q    <= holdoff_d;
      ctr_addr_q   <= ctr_addr_d;
      ack_q        <= ack_d;
    end
  end

  assign CTR_ACTIVE = ctr_active_q;
  assign PINC       = pinc_q;
  assign MINC       = minc_q;
  assign HOLDOFF    = holdoff_q;
  assign CTR_ADDR   = ctr_addr_q;
  assign ACK        = ack_q;
  assign CTROR      = |(pend_plus_q | pend_minus_q);

endmodule

// File: tb/tb_counter_cell_scheduler.sv
// Bench for counter_cell_scheduler: directed scenarios, a cycle-by-cycle
// behavioural reference built on pending sets and a counter-MCT run length,
// and hand-computed expectations at the key points of each scenario.
module tb_counter_cell_scheduler;

  localparam int NREQ  = 8;
  localparam int AW    = 3;
  localparam int BURST = 4;

  logic            CLOCK = 1'b0;
  logic            SIM_RST, T12, GOJAM, CTR_INH;
  logic [NREQ-1:0] REQ_PLUS, REQ_MINUS;
  logic            CTR_ACTIVE, PINC, MINC, CTROR, HOLDOFF;
  logic [AW-1:0]   CTR_ADDR;
  logic [NREQ-1:0] ACK;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [NREQ-1:0] m_plus, m_minus, m_prev_p, m_prev_m, e_ack;
  logic            e_active, e_pinc, e_minc, e_hold;
  logic [AW-1:0]   e_addr;
  int              m_run;

  // Burst scenario: expected address per boundary, -1 = forced hold, -2 = idle
  int s3_addr [8] = '{0, 1, 2, 3, -1, 4, 5, -2};

  counter_cell_scheduler #(.NREQ(NREQ), .AW(AW), .BURST(BURST)) dut (
    .CLOCK      (CLOCK),
    .SIM_RST    (SIM_RST),
    .T12        (T12),
    .GOJAM      (GOJAM),
    .CTR_INH    (CTR_INH),
    .REQ_PLUS   (REQ_PLUS),
    .REQ_MINUS  (REQ_MINUS),
    .CTR_ACTIVE (CTR_ACTIVE),
    .PINC       (PINC),
    .MINC       (MINC),
    .CTR_ADDR   (CTR_ADDR),
    .ACK        (ACK),
    .CTROR      (CTROR),
    .HOLDOFF    (HOLDOFF)
  );

  always #5 CLOCK = ~CLOCK;

  // One clock of reference behaviour, using the inputs seen at this edge
  task automatic model_step();
    int pick;
    if (SIM_RST || GOJAM) begin
      m_plus = '0; m_minus = '0; e_ack = '0;
      e_active = 1'b0; e_pinc = 1'b0; e_minc = 1'b0; e_hold = 1'b0;
      e_addr = '0; m_run = 0;
    end else begin
      e_ack = '0;
      if (T12) begin
        if (e_active && m_run == BURST) begin
          e_active = 1'b0; e_pinc = 1'b0; e_minc = 1'b0; e_hold = 1'b1;
          m_run = 0;
        end else begin
          e_hold = 1'b0;
          pick = -1;
          for (int i = 0; i < NREQ; i++)
            if (pick < 0 && (m_plus[i] || m_minus[i])) pick = i;
          if (pick >= 0 && !CTR_INH) begin
            m_run    = e_active ? m_run + 1 : 1;
            e_active = 1'b1;
            e_addr   = AW'(pick);
            e_ack    = 8'd1 << pick;
            if (m_plus[pick]) begin
              e_pinc = 1'b1; e_minc = 1'b0; m_plus[pick] = 1'b0;
            end else begin
              e_pinc = 1'b0; e_minc = 1'b1; m_minus[pick] = 1'b0;
            end
          end else begin
            e_active = 1'b0; e_pinc = 1'b0; e_minc = 1'b0; m_run = 0;
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (REQ_PLUS[i]  && !m_prev_p[i]) m_plus[i]  = 1'b1;
        if (REQ_MINUS[i] && !m_prev_m[i]) m_minus[i] = 1'b1;
      end
`ifdef CTR_CANCEL_EN
      for (int i = 0; i < NREQ; i++)
        if (m_plus[i] && m_minus[i]) begin
          m_plus[i] = 1'b0; m_minus[i] = 1'b0;
        end
`endif
    end
    m_prev_p = REQ_PLUS;
    m_prev_m = REQ_MINUS;
  endtask

  task automatic compare();
    logic [15:0] got, exp;
    got = {CTR_ACTIVE, PINC, MINC, CTR_ADDR, ACK, CTROR, HOLDOFF};
    exp = {e_active, e_pinc, e_minc, e_addr, e_ack, |(m_plus | m_minus), e_hold};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cycle_model t=%0t actual act/pinc/minc/addr/ack/ctror/hold=%h required=%h",
               $time, got, exp);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic t12();
    T12 = 1'b1;
    tick();
    T12 = 1'b0;
  endtask

  initial forever begin
    @(posedge CLOCK);
    model_step();
  end

  initial forever begin
    @(negedge CLOCK);
    if (chk_en) compare();
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    SIM_RST = 1'b1; T12 = 1'b0; GOJAM = 1'b0; CTR_INH = 1'b0;
    REQ_PLUS = 8'h02; REQ_MINUS = 8'h00;
    repeat (2) @(posedge CLOCK);
    #1;
    chk_en = 1'b1;
    chk("reset_outputs", {CTR_ACTIVE, PINC, MINC, CTR_ADDR, ACK, CTROR, HOLDOFF}, 16'h0000);
    SIM_RST = 1'b0;
    tick(); tick();
    chk("no_edge_from_held_line", 16'(CTROR), 16'd0);
    REQ_PLUS = 8'h00;
    tick();

    // Single request on cell 3
    REQ_PLUS = 8'h08; tick(); tick();
    t12();
    chk("s1_active", 16'(CTR_ACTIVE), 16'd1);
    chk("s1_pinc",   16'(PINC),       16'd1);
    chk("s1_addr",   16'(CTR_ADDR),   16'd3);
    chk("s1_ack",    16'(ACK),        16'h0008);
    tick();
    chk("s1_ack_one_cycle", 16'(ACK), 16'h0000);
    chk("s1_active_held", 16'(CTR_ACTIVE), 16'd1);
    t12();
    chk("s1_active_drop", 16'(CTR_ACTIVE), 16'd0);
    REQ_PLUS = 8'h00; tick();

    // Priority: cells 5 and 1 together
    REQ_PLUS = 8'h22; tick();
    t12();
    chk("s2_first_addr", 16'(CTR_ADDR), 16'd1);
    tick(); tick();
    t12();
    chk("s2_second_addr", 16'(CTR_ADDR), 16'd5);
    chk("s2_still_active", 16'(CTR_ACTIVE), 16'd1);
    tick();
    t12();
    chk("s2_idle", 16'(CTR_ACTIVE), 16'd0);
    REQ_PLUS = 8'h00; tick();

    // Burst limit with six cells pending
    REQ_PLUS = 8'h3F; tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      t12();
      if (s3_addr[k] == -1) begin
        chk("s3_hold_holdoff", 16'(HOLDOFF), 16'd1);
        chk("s3_hold_inactive", 16'(CTR_ACTIVE), 16'd0);
      end else if (s3_addr[k] == -2) begin
        chk("s3_end_idle", {14'd0, CTR_ACTIVE, HOLDOFF}, 16'd0);
      end else begin
        chk("s3_grant_active", 16'(CTR_ACTIVE), 16'd1);
        chk("s3_grant_addr", 16'(CTR_ADDR), 16'(s3_addr[k]));
      end
    end
    REQ_PLUS = 8'h00; tick();

    // Opposite-sign edges on cell 2 in the same cycle
    REQ_PLUS = 8'h04; REQ_MINUS = 8'h04; tick(); tick();
`ifdef CTR_CANCEL_EN
    chk("s4_cancel_ctror", 16'(CTROR), 16'd0);
    t12();
    chk("s4_cancel_no_grant", 16'(CTR_ACTIVE), 16'd0);
`else
    chk("s4_keep_ctror", 16'(CTROR), 16'd1);
    t12();
    chk("s4_plus_first", {13'd0, PINC, MINC, CTR_ACTIVE}, 16'b101);
    chk("s4_plus_addr", 16'(CTR_ADDR), 16'd2);
    tick();
    t12();
    chk("s4_minus_second", {13'd0, PINC, MINC, CTR_ACTIVE}, 16'b011);
    chk("s4_minus_addr", 16'(CTR_ADDR), 16'd2);
    tick();
    t12();
    chk("s4_idle", 16'(CTR_ACTIVE), 16'd0);
`endif
    REQ_PLUS = 8'h00; REQ_MINUS = 8'h00; tick();

    // GOJAM in the middle of a SERVE with three pending
    REQ_PLUS = 8'h50; REQ_MINUS = 8'h80; tick(); tick();
    t12();
    chk("s5_grant_addr", 16'(CTR_ADDR), 16'd4);
    tick();
    GOJAM = 1'b1; REQ_MINUS = 8'h88;
    tick();
    GOJAM = 1'b0;
    chk("s5_gojam_inactive", 16'(CTR_ACTIVE), 16'd0);
    chk("s5_gojam_ctror", 16'(CTROR), 16'd0);
    tick();
    t12();
    chk("s5_no_grant_after", 16'(CTR_ACTIVE), 16'd0);
    REQ_PLUS = 8'h00; REQ_MINUS = 8'h00; tick();

    // CTR_INH blocks the grant but keeps the request pending
    REQ_MINUS = 8'h01; tick();
    CTR_INH = 1'b1;
    t12();
    chk("s6_inh_no_grant", 16'(CTR_ACTIVE), 16'd0);
    chk("s6_inh_ctror", 16'(CTROR), 16'd1);
    CTR_INH = 1'b0; tick();
    t12();
    chk("s6_grant", {13'd0, CTR_ACTIVE, MINC, PINC}, 16'b110);
    chk("s6_addr", 16'(CTR_ADDR), 16'd0);
    tick();
    t12();
    REQ_MINUS = 8'h00; tick();

    // Edge coinciding with T12 waits one MCT
    REQ_PLUS = 8'h80; T12 = 1'b1;
    tick();
    T12 = 1'b0;
    chk("s7_late_edge_no_grant", 16'(CTR_ACTIVE), 16'd0);
    chk("s7_late_edge_pending", 16'(CTROR), 16'd1);
    tick();
    t12();
    chk("s7_grant_addr", 16'(CTR_ADDR), 16'd7);
    tick();
    t12();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
